// File: rtl/bubble_page_reader.sv
// Host-side bubble controller: sequences nBSS/nREPEN/nBSEN, packs DOUT0/DOUT1 slots into bytes
// and queues them in a ready/valid FIFO. Define BUBBLE_PAGE_READER_CRC_EN to add the CRC16 output.
module bubble_page_reader #(
    parameter int BIT_DIV        = 12,
    parameter int BSS_LEN        = 48,
    parameter int BSEN_DLY       = 480,
    parameter int SLOTS_PER_PAGE = 2048,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic        ABORT,
    input  logic        BOOTMODE,
    input  logic        SWAPMODE,
    output logic        nBSS,
    output logic        nBSEN,
    output logic        nREPEN,
    output logic        nBOOTEN,
    output logic        nSWAPEN,
    input  logic        DOUT0,
    input  logic        DOUT1,
    output logic [7:0]  RDATA,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN,
`ifdef BUBBLE_PAGE_READER_CRC_EN
    output logic [15:0] CRC16,
`endif
    output logic [2:0]  dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BSS_LAST  = 16'(BSS_LEN - 1);
    localparam logic [15:0] DLY_LAST  = 16'(BSEN_DLY - 1);
    localparam logic [15:0] DIV_LAST  = 16'(BIT_DIV - 1);
    localparam logic [15:0] DIV_HALF  = 16'(BIT_DIV / 2);
    localparam logic [15:0] SLOT_LAST = 16'(SLOTS_PER_PAGE - 1);
    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_BSS, S_DELAY, S_READ, S_DONE} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;       // phase counter in BSS/DELAY, bit divider in READ
    logic [15:0] slot, slot_nx;
    logic [1:0]  nib, nib_nx;       // slot position within the current byte
    logic [5:0]  shreg, shreg_nx;
    logic [7:0]  byte_nx;
    logic        byte_done, start_ok;
    logic        boot_q, swap_q;
    logic        sync0_a, sync0_b, sync1_a, sync1_b;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, accept;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        slot_nx   = slot;
        nib_nx    = nib;
        shreg_nx  = shreg;
        byte_nx   = {shreg, ~sync1_b, ~sync0_b};
        byte_done = 1'b0;
        start_ok  = 1'b0;
        nBSS      = 1'b1;
        nBSEN     = 1'b1;
        nREPEN    = 1'b1;
        nBOOTEN   = 1'b1;
        nSWAPEN   = 1'b1;
        DONE      = 1'b0;
        if (state != S_IDLE) begin
            nBOOTEN = ~boot_q;
            nSWAPEN = ~swap_q;
        end
        case (state)
            S_IDLE: begin
                if (START && !ABORT) begin
                    start_ok = 1'b1;
                    state_nx = S_BSS;
                    cnt_nx   = '0;
                end
            end
            S_BSS: begin
                nBSS = 1'b0;
                if (cnt == BSS_LAST) begin
                    state_nx = S_DELAY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_DELAY: begin
                nREPEN = 1'b0;
                if (cnt == DLY_LAST) begin
                    state_nx = S_READ;
                    cnt_nx   = '0;
                    slot_nx  = '0;
                    nib_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_READ: begin
                nBSEN = 1'b0;
                if (cnt == DIV_HALF) begin
                    shreg_nx  = byte_nx[5:0];
                    nib_nx    = nib + 2'd1;
                    byte_done = (nib == 2'd3);
                end
                if (cnt == DIV_LAST) begin
                    cnt_nx = '0;
                    if (slot == SLOT_LAST) state_nx = S_DONE;
                    else slot_nx = slot + 16'd1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_DONE: begin
                DONE     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // An abort terminates at once: a byte completing in this cycle is discarded too.
        if (ABORT && state != S_IDLE) begin
            state_nx  = S_IDLE;
            byte_done = 1'b0;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            slot    <= '0;
            nib     <= '0;
            shreg   <= '0;
            boot_q  <= 1'b0;
            swap_q  <= 1'b0;
            sync0_a <= 1'b1;
            sync0_b <= 1'b1;
            sync1_a <= 1'b1;
            sync1_b <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            slot    <= slot_nx;
            nib     <= nib_nx;
            shreg   <= shreg_nx;
            sync0_a <= DOUT0;
            sync0_b <= sync0_a;
            sync1_a <= DOUT1;
            sync1_b <= sync1_a;
            if (start_ok) begin
                boot_q <= BOOTMODE;
                swap_q <= SWAPMODE;
            end
        end
    end

    // RVALID/RREADY: a byte transfers on every cycle where both are high; RDATA is the
    // registered head entry and stays stable while RVALID is high and RREADY is low.
    assign full    = (count == DEPTH_W);
    assign RVALID  = (count != '0);
    assign pop     = RVALID & RREADY;
    assign accept  = byte_done & (~full | pop);
    assign RDATA   = mem[rd_ptr];
    assign BUSY    = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            OVERRUN <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= byte_nx;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (start_ok) OVERRUN <= 1'b0;
            else if (byte_done && !accept) OVERRUN <= 1'b1;
        end
    end

`ifdef BUBBLE_PAGE_READER_CRC_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) CRC16 <= 16'hFFFF;
        else if (start_ok) CRC16 <= 16'hFFFF;
        else if (byte_done) CRC16 <= crc_byte(CRC16, byte_nx);
    end
`endif
endmodule

// File: tb/tb_bubble_page_reader.sv
// Bench for bubble_page_reader: directed vector table plus randomized pages checked against
// a timeline/queue reference model derived from the access sequence rules.
module tb_bubble_page_reader;
    localparam int BIT_DIV  = 4;
    localparam int BSS_LEN  = 2;
    localparam int BSEN_DLY = 3;
    localparam int SLOTS    = 20;
    localparam int DEPTH    = 4;
    localparam int R0       = BSS_LEN + BSEN_DLY;
    localparam int DONE_R   = R0 + SLOTS * BIT_DIV;

    logic MCLK = 1'b0, nRESET = 1'b0, START = 1'b0, ABORT = 1'b0;
    logic BOOTMODE = 1'b0, SWAPMODE = 1'b0, DOUT0 = 1'b1, DOUT1 = 1'b1, RREADY = 1'b0;
    logic nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN, RVALID, BUSY, DONE, OVERRUN;
    logic [7:0] RDATA;
    logic [2:0] dbg_state;
`ifdef BUBBLE_PAGE_READER_CRC_EN
    logic [15:0] CRC16;
`endif

    bubble_page_reader #(
        .BIT_DIV(BIT_DIV), .BSS_LEN(BSS_LEN), .BSEN_DLY(BSEN_DLY),
        .SLOTS_PER_PAGE(SLOTS), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .MCLK(MCLK), .nRESET(nRESET), .START(START), .ABORT(ABORT),
        .BOOTMODE(BOOTMODE), .SWAPMODE(SWAPMODE),
        .nBSS(nBSS), .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN), .nSWAPEN(nSWAPEN),
        .DOUT0(DOUT0), .DOUT1(DOUT1), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN),
`ifdef BUBBLE_PAGE_READER_CRC_EN
        .CRC16(CRC16),
`endif
        .dbg_state(dbg_state)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        bit         boot;
        bit         swap;
        bit         d1;
        bit         d0;
        int         rdy_mode;
        int         abort_at;
        int         exp_kept;
        bit         exp_ovr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t        vecs[5];
    logic        dout0_s[SLOTS];
    logic        dout1_s[SLOTS];
    logic [7:0]  exp_q[$];
    logic        ovr_m;
    logic [15:0] crc_m;
    int          checks, failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        bit fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [7:0] page_byte(input int j);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = {b[5:0], ~dout1_s[4*j+k], ~dout0_s[4*j+k]};
        return b;
    endfunction

    task automatic fifo_step(input bit rdy, input bit push, input logic [7:0] b);
        bit pop;
        pop = (exp_q.size() != 0) && rdy;
        if (push) crc_m = crc_upd(crc_m, b);
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else ovr_m = 1'b1;
        end
    endtask

    task automatic observe(input string tag, input bit busy_e, input bit [4:0] n_e, input bit done_e);
        check({tag, ".n_outs"}, 32'({nBSS, nREPEN, nBSEN, nBOOTEN, nSWAPEN}), 32'(n_e));
        check({tag, ".busy_done"}, 32'({BUSY, DONE}), 32'({busy_e, done_e}));
        check({tag, ".rvalid"}, 32'(RVALID), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, ".rdata"}, 32'(RDATA), 32'(exp_q[0]));
        check({tag, ".overrun"}, 32'(OVERRUN), 32'(ovr_m));
    endtask

    // Walks one access cycle by cycle; r counts cycles after the edge that accepts START.
    task automatic run_page(input string tag, input bit boot, input bit swap, input int abort_at,
                            input int rdy_mode, input bit noise);
        int r_end, c, s;
        bit busy_e, rdy, push;
        bit [4:0] n_e;
        r_end = (abort_at >= 0) ? abort_at : DONE_R;
        for (int r = -1; r <= r_end + 1; r++) begin
            busy_e = (r >= 0) && (r <= r_end);
            c = r - R0;
            n_e[4] = !(busy_e && r < BSS_LEN);
            n_e[3] = !(busy_e && r >= BSS_LEN && r < R0);
            n_e[2] = !(busy_e && c >= 0 && r < DONE_R);
            n_e[1] = !(busy_e && boot);
            n_e[0] = !(busy_e && swap);
            observe(tag, busy_e, n_e, busy_e && r == DONE_R);
            START = (r == -1) || (noise && busy_e && $urandom_range(0, 7) == 0);
            ABORT = (abort_at >= 0) && (r == abort_at);
            if (r == -1) begin
                BOOTMODE = boot;
                SWAPMODE = swap;
            end else if (noise) begin
                BOOTMODE = 1'($urandom);
                SWAPMODE = 1'($urandom);
            end
            rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
            RREADY = rdy;
            if (c + 2 >= 0 && (c + 2) % BIT_DIV == 0 && (c + 2) / BIT_DIV < SLOTS) begin
                s = (c + 2) / BIT_DIV;
                DOUT0 = dout0_s[s];
                DOUT1 = dout1_s[s];
            end
            push = busy_e && !(abort_at >= 0 && r == abort_at) && c >= 0 && c < SLOTS * BIT_DIV
                   && (c % (4 * BIT_DIV)) == (3 * BIT_DIV + BIT_DIV / 2);
            fifo_step(rdy, push, push ? page_byte(c / (4 * BIT_DIV)) : 8'h00);
            if (r == -1) begin
                ovr_m = 1'b0;
                crc_m = 16'hFFFF;
            end
            @(posedge MCLK); #1;
        end
        START = 1'b0;
        ABORT = 1'b0;
`ifdef BUBBLE_PAGE_READER_CRC_EN
        check({tag, ".crc16"}, 32'(CRC16), 32'(crc_m));
`endif
    endtask

    task automatic drain(input string tag, input int exp_n, input logic [7:0] exp_b,
                         input bit exp_ovr, input bit table_chk);
        int n;
        n = 0;
        if (table_chk) check({tag, ".tbl_overrun"}, 32'(OVERRUN), 32'(exp_ovr));
        for (int i = 0; i < DEPTH + 2; i++) begin
            observe(tag, 1'b0, 5'b11111, 1'b0);
            if (table_chk && RVALID) begin
                n++;
                check({tag, ".tbl_byte"}, 32'(RDATA), 32'(exp_b));
            end
            RREADY = 1'b1;
            fifo_step(1'b1, 1'b0, 8'h00);
            @(posedge MCLK); #1;
        end
        RREADY = 1'b0;
        if (table_chk) check({tag, ".tbl_kept"}, n, exp_n);
    endtask

    initial begin
        string tag;
        int ab;
        bit bt, sw;
        checks   = 0;
        failures = 0;
        ovr_m    = 1'b0;
        crc_m    = 16'hFFFF;

        repeat (3) @(posedge MCLK);
        #1;
        check("rst.n_outs", 32'({nBSS, nREPEN, nBSEN, nBOOTEN, nSWAPEN}), 32'h1F);
        check("rst.busy_done", 32'({BUSY, DONE}), 32'h0);
        check("rst.rvalid", 32'(RVALID), 32'h0);
        check("rst.rdata", 32'(RDATA), 32'h0);
        check("rst.overrun", 32'(OVERRUN), 32'h0);
        @(negedge MCLK) nRESET = 1'b1;
        @(posedge MCLK); #1;

        //        boot  swap  d1    d0    rdy ab  kept ovr   byte
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, -1, 4, 1'b1, 8'hAA};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, R0 + 6 * BIT_DIV, 1, 1'b0, 8'h55};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, -1, 0, 1'b0, 8'hFF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, -1, 0, 1'b0, 8'hAA};
        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("vec%0d", i);
            for (int s = 0; s < SLOTS; s++) begin
                dout1_s[s] = ~vecs[i].d1;
                dout0_s[s] = ~vecs[i].d0;
            end
            run_page(tag, vecs[i].boot, vecs[i].swap, vecs[i].abort_at, vecs[i].rdy_mode, 1'b0);
            drain(tag, vecs[i].exp_kept, vecs[i].exp_byte, vecs[i].exp_ovr, 1'b1);
        end

        // Latched BOOTMODE must hold while the input toggles; STARTs while busy are ignored.
        for (int s = 0; s < SLOTS; s++) begin
            dout0_s[s] = 1'($urandom);
            dout1_s[s] = 1'($urandom);
        end
        run_page("boot_hold", 1'b1, 1'b0, -1, 1, 1'b1);
        drain("boot_hold", 0, 8'h00, 1'b0, 1'b0);

        for (int p = 0; p < 10; p++) begin
            for (int s = 0; s < SLOTS; s++) begin
                dout0_s[s] = 1'($urandom);
                dout1_s[s] = 1'($urandom);
            end
            ab = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, DONE_R - 1));
            bt = 1'($urandom);
            sw = 1'($urandom);
            tag = $sformatf("rand%0d", p);
            run_page(tag, bt, sw, ab, 2, 1'b1);
            drain(tag, 0, 8'h00, 1'b0, 1'b0);
        end

        // Fill the FIFO, start another access, then reset in the middle of it.
        for (int s = 0; s < SLOTS; s++) begin
            dout0_s[s] = 1'($urandom);
            dout1_s[s] = 1'($urandom);
        end
        run_page("pre_rst", 1'b1, 1'b1, -1, 0, 1'b0);
        check("pre_rst.rvalid_full", 32'(RVALID), 32'h1);
        START = 1'b1;
        @(posedge MCLK); #1;
        START = 1'b0;
        repeat (8) @(posedge MCLK);
        #3;
        nRESET = 1'b0;
        #1;
        check("mid_rst.n_outs", 32'({nBSS, nREPEN, nBSEN, nBOOTEN, nSWAPEN}), 32'h1F);
        check("mid_rst.busy", 32'(BUSY), 32'h0);
        check("mid_rst.rvalid", 32'(RVALID), 32'h0);
        check("mid_rst.rdata", 32'(RDATA), 32'h0);
        check("mid_rst.overrun", 32'(OVERRUN), 32'h0);
        exp_q.delete();
        ovr_m = 1'b0;
        @(negedge MCLK) nRESET = 1'b1;
        @(posedge MCLK); #1;
        observe("post_rst", 1'b0, 5'b11111, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bubble_page_reader.md
Name: bubble_page_reader

Overview:
- Host-side counterpart of the bubble emulator core: plays the role of the arcade board's bubble controller.
- Generates the nBSS / nBSEN / nREPEN / nBOOTEN / nSWAPEN access sequence.
- Samples the DOUT0/DOUT1 bit streams, packs them into bytes and presents the bytes through a small ready/valid FIFO.
- Used on bench/loopback builds to read back a page from the emulator and check the flash image path end to end.

Parameters:
- BIT_DIV, 12: MCLK cycles per bit slot (48 MHz / 4 MHz).
- BSS_LEN, 48: MCLK cycles nBSS is held low.
- BSEN_DLY, 480: MCLK cycles from nBSS release to nBSEN assertion.
- SLOTS_PER_PAGE, 2048: bit slots per page read; must be a multiple of 4.
- FIFO_DEPTH, 4: output byte FIFO entries; power of 2.

Ports:
- MCLK  input  1  system clock, 48 MHz.
- nRESET  input  1  reset, asynchronous assert, active-low.
- START  input  1  one-cycle request to read one page; honoured only in IDLE.
- ABORT  input  1  one-cycle request to terminate the access immediately.
- BOOTMODE  input  1  sampled at START; 1 drives nBOOTEN low for the whole access.
- SWAPMODE  input  1  sampled at START; 1 drives nSWAPEN low for the whole access.
- nBSS  output  1  bubble start strobe.
- nBSEN  output  1  bubble shift enable.
- nREPEN  output  1  replicate enable.
- nBOOTEN  output  1  boot loop enable.
- nSWAPEN  output  1  swap enable.
- DOUT0  input  1  bubble data channel 0, asynchronous, low = logic 1.
- DOUT1  input  1  bubble data channel 1, asynchronous, low = logic 1.
- RDATA  output  8  FIFO head byte.
- RVALID  output  1  FIFO non-empty.
- RREADY  input  1  consumer pops head when RVALID & RREADY.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when a page completes normally.
- OVERRUN  output  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - All n* outputs = 1.
  - BUSY, DONE, OVERRUN, RVALID = 0; RDATA = 0.
  - FIFO empty; state IDLE.
- Input synchronisation: DOUT0/DOUT1 each pass through a 2-flop synchroniser before sampling.
- FSM states: IDLE, BSS, DELAY, READ, DONE.
- IDLE:
  - On START, latch BOOTMODE/SWAPMODE, clear OVERRUN, go to BSS next cycle.
  - nBOOTEN = ~boot_latched and nSWAPEN = ~swap_latched from the BSS entry cycle until return to IDLE.
- BSS: nBSS = 0 for exactly BSS_LEN cycles, then go to DELAY.
- DELAY: nBSS = 1 and nREPEN = 0 for exactly BSEN_DLY cycles, then go to READ.
- READ:
  - nBSEN = 0.
  - Divider counts 0..BIT_DIV-1; at count == BIT_DIV/2, sample both synced channels inverted (d = ~DOUT).
  - Slot pair {d1,d0} shifts into the byte register MSB-first; 4 slots make one byte.
  - The completed byte is pushed on the same cycle as the 4th sample.
  - After SLOTS_PER_PAGE slots (including the full last slot), go to DONE.
- DONE: nBSEN = 1, DONE = 1 for one cycle, then go to IDLE.
- START outside IDLE: ignored.
- ABORT:
  - Any non-IDLE state goes to IDLE next cycle; all n* outputs go to 1.
  - Partial byte discarded; FIFO contents retained; no DONE pulse.
  - ABORT wins over a simultaneous START.
- FIFO:
  - Push while full with no pop: byte dropped, OVERRUN set.
  - Push and pop in the same cycle while full: legal, no drop.
  - Pop while empty: no effect.
  - RDATA is registered at the head entry; no combinational path from RREADY to RDATA.
- Latency: first pushed byte appears on RVALID 1 cycle after the 4th sample of the READ state.
- Reset mid-operation: immediate return to reset values; FIFO flushed.

Optional Feature:
- Macro BUBBLE_PAGE_READER_CRC_EN.
- When defined:
  - Adds output CRC16 [15:0]: CRC-16/CCITT, poly 0x1021, init 0xFFFF, MSB-first.
  - Updated over every byte as it completes (including dropped bytes).
  - Reset to 0xFFFF at START; holds its value after DONE/ABORT.
- When undefined: the port and logic are absent.

Test Plan:
- Params BIT_DIV=4, BSS_LEN=2, BSEN_DLY=3, SLOTS_PER_PAGE=8; START -> nBSS low 2 cycles, nREPEN low 3 cycles, nBSEN low 32 cycles, DONE pulse, BUSY falls the cycle after DONE.
- Same params, DOUT1/DOUT0 held 0/1 (d1=1, d0=0) -> bytes 0xAA, 0xAA in FIFO; RVALID rises 1 cycle after the 4th sample.
- RREADY=0, FIFO_DEPTH=4, SLOTS_PER_PAGE=20 -> 4 bytes kept, 5th dropped, OVERRUN=1; the next START clears OVERRUN.
- ABORT asserted in READ after 6 slots -> next cycle all n* = 1, BUSY=0, FIFO holds exactly 1 byte, no DONE pulse.
- BOOTMODE=1 at START, then toggled during READ -> nBOOTEN stays low throughout and goes high in IDLE; START during BUSY is ignored.
- CRC_EN build, bytes 0x31..0x39 ("123456789") -> CRC16 = 0x29B1.
